grid_walk_serial_stepper: RTL

//  Walker position controller for the grid_walk design. Accepts move commands
//  (direction + step) and updates an (x,y) coordinate using a bit-serial
//  add/subtract: one full-adder/subtractor slice is reused over WIDTH cycles.

---
 rtl/grid_walk_serial_stepper_pkg.sv | 18 +
 rtl/grid_walk_serial_stepper_if.sv | 16 +
 rtl/grid_walk_serial_stepper_slice.sv | 34 +++
 rtl/grid_walk_serial_stepper.sv | 118 +++++++++++
 4 files changed

// File: rtl/grid_walk_serial_stepper_pkg.sv
// Shared encodings for the grid_walk walker: move directions, stepper FSM states,
// and the default coordinate width.
package grid_walk_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] DIR_PX = 2'b00;
  localparam logic [1:0] DIR_MX = 2'b01;
  localparam logic [1:0] DIR_PY = 2'b10;
  localparam logic [1:0] DIR_MY = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/grid_walk_serial_stepper_if.sv
// Move-command channel: the command source is the master, the stepper is the slave.
interface grid_walk_serial_stepper_if
  import grid_walk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_dir;
  logic [WIDTH-1:0] cmd_step;

  modport master (output cmd_valid, output cmd_dir, output cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_step, output cmd_ready);

endinterface

// File: rtl/grid_walk_serial_stepper_slice.sv
// One-bit add/subtract cell with its carry flop; the carry is preloaded with
// adsub so that subtraction becomes a + ~b + 1.
module serial_addsub_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic b_i,
  input  logic adsub_i,
  input  logic load_i,
  input  logic en_i,
  output logic sum_o,
  output logic carry_o
);

  logic carry_q;
  logic bx;
  logic cout_d;

  assign bx      = b_i ^ adsub_i;
  assign sum_o   = a_i ^ bx ^ carry_q;
  assign cout_d  = (a_i & bx) | (bx & carry_q) | (a_i & carry_q);
  assign carry_o = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= adsub_i;
    end else if (en_i) begin
      carry_q <= cout_d;
    end
  end

endmodule

// File: rtl/grid_walk_serial_stepper.sv
// Walker position controller: applies one move per WIDTH+2 cycles using a
// bit-serial adder, rejecting moves that would leave the grid.
module grid_walk_serial_stepper
  import grid_walk_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  grid_walk_serial_stepper_if.slave  cmd,
  output logic [WIDTH-1:0]           pos_x,
  output logic [WIDTH-1:0]           pos_y,
  output logic                       done,
  output logic                       oob,
  output logic [CNT_W-1:0]           move_count
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic             adsub_q;
  logic             axis_y_q;
  logic [BW-1:0]    bitcnt_q;
  logic [WIDTH-1:0] pos_x_q;
  logic [WIDTH-1:0] pos_y_q;
  logic             done_q;
  logic             oob_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic slice_adsub;
  logic sum;
  logic carry;

  assign accept      = (state_q == ST_IDLE) && cmd.cmd_valid;
  // The carry flop loads straight from the command on the accept edge.
  assign slice_adsub = (state_q == ST_IDLE) ? cmd.cmd_dir[0] : adsub_q;

  serial_addsub_slice u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (opa_q[0]),
    .b_i     (opb_q[0]),
    .adsub_i (slice_adsub),
    .load_i  (accept),
    .en_i    (state_q == ST_SHIFT),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      adsub_q  <= 1'b0;
      axis_y_q <= 1'b0;
      bitcnt_q <= '0;
      pos_x_q  <= WIDTH'(START_X);
      pos_y_q  <= WIDTH'(START_Y);
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      oob_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            opa_q    <= cmd.cmd_dir[1] ? pos_y_q : pos_x_q;
            opb_q    <= cmd.cmd_step;
            adsub_q  <= cmd.cmd_dir[0];
            axis_y_q <= cmd.cmd_dir[1];
            bitcnt_q <= '0;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res_q    <= {sum, res_q[WIDTH-1:1]};
          opa_q    <= {1'b0, opa_q[WIDTH-1:1]};
          opb_q    <= {1'b0, opb_q[WIDTH-1:1]};
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == BW'(WIDTH - 1)) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // Add overflows with carry=1; subtract underflows with no carry out.
          if (carry != adsub_q) begin
            oob_q <= 1'b1;
          end else begin
            if (axis_y_q) pos_y_q <= res_q;
            else          pos_x_q <= res_q;
            cnt_q <= cnt_q + 1'b1;
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;
  assign done          = done_q;
  assign oob           = oob_q;
  assign move_count    = cnt_q;

endmodule
